leaf_switch: RTL and testbench

- Router-side endpoint of the NI flit protocol. One leaf switch serves one group of four GPU NIs (leaf 0-3) and has one uplink to the group-level fabric.
- Accepts 16-bit flits from the four NIs and routes them on the 6-bit header (hdr[15:12] = group, hdr[11:10] = leaf). A flit goes to a local NI when its group equals GROUP_ID, otherwise to the uplink.
- Flits arriving on the uplink are delivered to the addressed local NI.
- Per-input FIFOs, with a round-robin arbiter per output.

---
 rtl/leaf_switch.sv | 213 +++++++++++++++++++++
 tb/tb_leaf_switch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_switch.sv
// Leaf switch: four NI ports plus one uplink, a FIFO per input and a round-robin arbiter per output.
// Define LEAF_SW_STATS_EN to add a saturating dropped-flit counter output (drop_cnt).
module leaf_switch #(
    parameter int DATA_W   = 16,
    parameter int GROUP_ID = 5,
    parameter int IN_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef LEAF_SW_STATS_EN
    output logic [15:0]         drop_cnt,
`endif
    input  logic [4*DATA_W-1:0] loc_data_in,
    input  logic [3:0]          loc_valid_in,
    output logic [3:0]          loc_ready_out,
    output logic [4*DATA_W-1:0] loc_data_out,
    output logic [3:0]          loc_valid_out,
    output logic [DATA_W-1:0]   up_data_out,
    output logic                up_valid_out,
    input  logic                up_ready_in,
    input  logic [DATA_W-1:0]   up_data_in,
    input  logic                up_valid_in,
    output logic                up_ready_out
);
    localparam int NPORT = 5;
    localparam int UP    = 4;
    localparam int PW    = $clog2(IN_DEPTH);
    localparam int CW    = PW + 1;

    logic [NPORT-1:0][DATA_W-1:0] head;
    logic [NPORT-1:0][2:0]        dest;
    logic [NPORT-1:0]             head_valid;
    logic [NPORT-1:0]             drop;
    logic [NPORT-1:0]             pop;
    logic [NPORT-1:0]             out_grant;
    logic [NPORT-1:0][2:0]        out_win;
    logic                         up_valid_reg;
    logic [DATA_W-1:0]            up_data_reg;

    // Input side: FIFO plus route decode of its head
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_in
        logic [DATA_W-1:0] mem [IN_DEPTH];
        logic [PW-1:0]     wr_ptr_reg;
        logic [PW-1:0]     rd_ptr_reg;
        logic [CW-1:0]     count_reg;
        logic [CW-1:0]     count_next;
        logic [DATA_W-1:0] wr_data;
        logic              strobe;
        logic              push;
        logic              is_local;
        logic              is_null;

        assign push       = strobe && (count_reg != CW'(IN_DEPTH));
        assign count_next = count_reg + CW'(push) - CW'(pop[gi]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                count_reg <= count_next;
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop[gi])
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr_reg] <= wr_data;
        end

        assign head[gi]       = mem[rd_ptr_reg];
        assign head_valid[gi] = (count_reg != '0);
        assign is_local       = (head[gi][DATA_W-1 -: 4] == 4'(GROUP_ID));
        assign is_null        = (head[gi][DATA_W-1 -: 6] == 6'd0);
        assign dest[gi]       = is_local ? {1'b0, head[gi][DATA_W-5 -: 2]} : 3'(UP);

        if (gi < UP) begin : g_loc
            logic ready_reg;

            assign wr_data  = loc_data_in[gi*DATA_W +: DATA_W];
            assign strobe   = loc_valid_in[gi];
            assign drop[gi] = head_valid[gi] && is_null;

            // NI reacts a cycle late, so credit is withdrawn one entry early
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    ready_reg <= 1'b1;
                else
                    ready_reg <= (count_next <= CW'(IN_DEPTH - 2));
            end
            assign loc_ready_out[gi] = ready_reg;
        end else begin : g_up
            assign wr_data      = up_data_in;
            assign strobe       = up_valid_in && up_ready_out;
            assign drop[gi]     = head_valid[gi] && (is_null || !is_local);
            assign up_ready_out = (count_reg != CW'(IN_DEPTH));
        end
    end

    // Output side: round-robin arbiter and output register per output
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_arb
        logic [2:0]         ptr_reg;
        logic [NPORT-1:0]   req;
        logic [2*NPORT-1:0] req2;
        logic [3:0]         sel;
        logic [2:0]         win;
        logic               found;
        logic               avail;

        always_comb begin
            for (int i = 0; i < NPORT; i++)
                req[i] = head_valid[i] && !drop[i] && (dest[i] == 3'(gi));
        end
        assign req2 = {req, req};

        always_comb begin
            found = 1'b0;
            win   = '0;
            sel   = '0;
            for (int k = 0; k < NPORT; k++) begin
                sel = {1'b0, ptr_reg} + 4'(k);
                if (!found && req2[sel]) begin
                    found = 1'b1;
                    win   = (sel >= 4'(NPORT)) ? 3'(sel - 4'(NPORT)) : sel[2:0];
                end
            end
        end

        assign out_grant[gi] = found && avail;
        assign out_win[gi]   = win;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                ptr_reg <= '0;
            else if (out_grant[gi])
                ptr_reg <= (win == 3'(UP)) ? 3'd0 : win + 3'd1;
        end

        if (gi < UP) begin : g_loc_out
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            assign avail = 1'b1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= out_grant[gi];
                    if (out_grant[gi])
                        data_reg <= head[win];
                end
            end
            assign loc_data_out[gi*DATA_W +: DATA_W] = data_reg;
            assign loc_valid_out[gi]                 = valid_reg;
        end else begin : g_up_out
            // A new flit may enter only if the held one leaves on this edge
            assign avail = !up_valid_reg || up_ready_in;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    up_data_reg  <= '0;
                    up_valid_reg <= 1'b0;
                end else if (out_grant[gi]) begin
                    up_data_reg  <= head[win];
                    up_valid_reg <= 1'b1;
                end else if (up_ready_in) begin
                    up_valid_reg <= 1'b0;
                end
            end
            assign up_data_out  = up_data_reg;
            assign up_valid_out = up_valid_reg;
        end
    end

    // A head leaves its FIFO when dropped or granted
    always_comb begin
        pop = drop;
        for (int o = 0; o < NPORT; o++) begin
            if (out_grant[o])
                pop[out_win[o]] = 1'b1;
        end
    end

`ifdef LEAF_SW_STATS_EN
    logic [15:0] drop_cnt_reg;
    logic [2:0]  drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NPORT; i++)
            drop_num = drop_num + 3'(drop[i]);
    end
    assign drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_num);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt_reg <= '0;
        else
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
    assign drop_cnt = drop_cnt_reg;
`else
    // Dropped heads are simply popped; nothing is counted.
`endif

endmodule

// File: tb/tb_leaf_switch.sv
// Directed bench for leaf_switch: per-output expectation queues checked as flits emerge,
// plus cycle-exact checks at the points where timing matters.
module tb_leaf_switch;
    localparam int DATA_W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [4*DATA_W-1:0] loc_data_in;
    logic [3:0]          loc_valid_in;
    logic [3:0]          loc_ready_out;
    logic [4*DATA_W-1:0] loc_data_out;
    logic [3:0]          loc_valid_out;
    logic [DATA_W-1:0]   up_data_out;
    logic                up_valid_out;
    logic                up_ready_in;
    logic [DATA_W-1:0]   up_data_in;
    logic                up_valid_in;
    logic                up_ready_out;
`ifdef LEAF_SW_STATS_EN
    logic [15:0]         drop_cnt;
`endif

    leaf_switch #(.DATA_W(DATA_W), .GROUP_ID(5), .IN_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef LEAF_SW_STATS_EN
        .drop_cnt      (drop_cnt),
`endif
        .loc_data_in   (loc_data_in),
        .loc_valid_in  (loc_valid_in),
        .loc_ready_out (loc_ready_out),
        .loc_data_out  (loc_data_out),
        .loc_valid_out (loc_valid_out),
        .up_data_out   (up_data_out),
        .up_valid_out  (up_valid_out),
        .up_ready_in   (up_ready_in),
        .up_data_in    (up_data_in),
        .up_valid_in   (up_valid_in),
        .up_ready_out  (up_ready_out)
    );

    always #5 clk = ~clk;

    int                vectors     = 0;
    int                miscompares = 0;
    int                sent;
    logic [3:0]        ready_seen;
    logic [DATA_W-1:0] exp_q [5][$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic take(input int port, input logic [DATA_W-1:0] data);
        string tag;
        tag = $sformatf("out%0d", port);
        vectors++;
        assert (exp_q[port].size() != 0) else begin
            miscompares++;
            $error("FAIL %s_unexpected: observed flit %h expected no flit", tag, data);
        end
        if (exp_q[port].size() != 0)
            check(tag, 64'(data), 64'(exp_q[port].pop_front()));
    endtask

    function automatic int pending();
        int total;
        total = 0;
        for (int p = 0; p < 5; p++)
            total += exp_q[p].size();
        return total;
    endfunction

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (pending() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_left"}, 64'(pending()), 64'd0);
    endtask

    task automatic drive_loc(input int n, input logic [DATA_W-1:0] d);
        loc_valid_in[n] = 1'b1;
        loc_data_in[n*DATA_W +: DATA_W] = d;
    endtask

    // NI rule: only send when credit was seen in the previous cycle
    task automatic send_loc(input int n, input logic [DATA_W-1:0] d);
        check($sformatf("credit%0d", n), 64'(ready_seen[n]), 64'd1);
        drive_loc(n, d);
    endtask

    initial begin
        reset        = 1'b1;
        loc_data_in  = '0;
        loc_valid_in = '0;
        up_ready_in  = 1'b1;
        up_data_in   = '0;
        up_valid_in  = 1'b0;
        ready_seen   = 4'hF;

        fork
            forever begin
                @(negedge clk);
                ready_seen = loc_ready_out;
                if (!reset) begin
                    for (int n = 0; n < 4; n++) begin
                        if (loc_valid_out[n])
                            take(n, loc_data_out[n*DATA_W +: DATA_W]);
                    end
                    if (up_valid_out && up_ready_in)
                        take(4, up_data_out);
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: observed timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (2) tick();
        check("rst_loc_valid", 64'(loc_valid_out), 64'd0);
        check("rst_loc_data", 64'(loc_data_out), 64'd0);
        check("rst_loc_ready", 64'(loc_ready_out), 64'hF);
        check("rst_up_valid", 64'(up_valid_out), 64'd0);
        check("rst_up_data", 64'(up_data_out), 64'd0);
        check("rst_up_ready", 64'(up_ready_out), 64'd1);
`ifdef LEAF_SW_STATS_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        reset = 1'b0;
        tick();

        // Loopback on leaf 1: pulse two edges after the strobe
        send_loc(1, 16'h5403);
        exp_q[1].push_back(16'h5403);
        tick();
        loc_valid_in = '0;
        tick();
        check("t1_valid", 64'(loc_valid_out[1]), 64'd1);
        check("t1_data", 64'(loc_data_out[DATA_W +: DATA_W]), 64'h5403);
        tick();
        check("t1_pulse_end", 64'(loc_valid_out[1]), 64'd0);

        // Uplink held not-ready
        up_ready_in = 1'b0;
        send_loc(0, 16'h8C55);
        exp_q[4].push_back(16'h8C55);
        tick();
        send_loc(0, 16'h9001);
        exp_q[4].push_back(16'h9001);
        tick();
        loc_valid_in = '0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t2_hold_valid%0d", c), 64'(up_valid_out), 64'd1);
            check($sformatf("t2_hold_data%0d", c), 64'(up_data_out), 64'h8C55);
            tick();
        end
        up_ready_in = 1'b1;
        check("t2_before_release", 64'(up_data_out), 64'h8C55);
        tick();
        check("t2_next_valid", 64'(up_valid_out), 64'd1);
        check("t2_next_data", 64'(up_data_out), 64'h9001);
        tick();
        check("t2_idle", 64'(up_valid_out), 64'd0);
        wait_drain("t2");

        // Four sources contend for leaf 2
        check("t3_up_ready", 64'(up_ready_out), 64'd1);
        send_loc(0, 16'h5800);
        send_loc(2, 16'h5822);
        send_loc(3, 16'h5833);
        up_valid_in = 1'b1;
        up_data_in  = 16'h5844;
        exp_q[2].push_back(16'h5800);
        exp_q[2].push_back(16'h5822);
        exp_q[2].push_back(16'h5833);
        exp_q[2].push_back(16'h5844);
        tick();
        loc_valid_in = '0;
        up_valid_in  = 1'b0;
        wait_drain("t3_round1");
        send_loc(3, 16'h5A33);
        send_loc(0, 16'h5A00);
        exp_q[2].push_back(16'h5A00);
        exp_q[2].push_back(16'h5A33);
        tick();
        loc_valid_in = '0;
        wait_drain("t3_round2");

        // Uplink: foreign group dropped, local one delivered
        up_valid_in = 1'b1;
        up_data_in  = 16'h1000;
        tick();
        up_data_in  = 16'h5C01;
        exp_q[3].push_back(16'h5C01);
        tick();
        up_valid_in = 1'b0;
        wait_drain("t4");
`ifdef LEAF_SW_STATS_EN
        check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Leaf 0 streams into a stalled uplink
        up_ready_in = 1'b0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            if (ready_seen[0] && sent < 8) begin
                drive_loc(0, 16'h7000 + 16'(sent));
                exp_q[4].push_back(16'h7000 + 16'(sent));
                sent++;
            end else begin
                loc_valid_in[0] = 1'b0;
            end
            tick();
        end
        loc_valid_in = '0;
        check("t5_sent_stalled", 64'(sent), 64'd5);
        check("t5_ready_low", 64'(loc_ready_out[0]), 64'd0);
        up_ready_in = 1'b1;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            if (ready_seen[0]) begin
                drive_loc(0, 16'h7000 + 16'(sent));
                exp_q[4].push_back(16'h7000 + 16'(sent));
                sent++;
            end else begin
                loc_valid_in[0] = 1'b0;
            end
            tick();
        end
        loc_valid_in = '0;
        check("t5_sent_total", 64'(sent), 64'd8);
        wait_drain("t5");

        // Reset mid-burst discards everything buffered
        up_ready_in = 1'b0;
        for (int n = 0; n < 4; n++)
            send_loc(n, 16'h7100 + 16'(n));
        tick();
        for (int n = 0; n < 4; n++)
            send_loc(n, (n == 1) ? 16'h5811 : 16'h7200 + 16'(n));
        tick();
        loc_valid_in = '0;
        reset = 1'b1;
        for (int p = 0; p < 5; p++)
            exp_q[p].delete();
        tick();
        check("t6_loc_valid", 64'(loc_valid_out), 64'd0);
        check("t6_up_valid", 64'(up_valid_out), 64'd0);
        check("t6_loc_ready", 64'(loc_ready_out), 64'hF);
        check("t6_up_ready", 64'(up_ready_out), 64'd1);
        reset       = 1'b0;
        up_ready_in = 1'b1;
        repeat (20) tick();
`ifdef LEAF_SW_STATS_EN
        check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        send_loc(2, 16'h5402);
        exp_q[1].push_back(16'h5402);
        tick();
        loc_valid_in = '0;
        wait_drain("t6_alive");
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
